// File: rtl/ifetch_pkg.sv
// rtl/ifetch_pkg.sv - shared constants and types for the instruction fetch unit
// Contents:
//   XLEN_DEF      default datapath / PC width
//   RESET_PC_DEF  default PC loaded on reset
//   NOP           canonical no-op instruction encoding (addi x0, x0, 0)
//   fetch_entry_t one buffered fetch result {inst, pc} at default width
package ifetch_pkg;

  localparam int          XLEN_DEF     = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP          = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN_DEF-1:0] inst;
    logic [XLEN_DEF-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// rtl/ifetch_fifo.sv - synchronous FIFO buffering fetched {inst, pc} entries
// Parameters: WIDTH entry width, DEPTH entries (power of two, >= 2)
// Ports:
//   clk, rst     clock, synchronous active-high reset (clears storage too)
//   push, din    write one entry; caller guarantees the FIFO is not full
//   pop          remove head entry; ignored when empty
//   flush        discard all entries; dominates push and pop
//   dout         head entry
//   count        number of stored entries
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   CNT_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_pop;

  assign do_pop = pop && (count != '0);
  assign dout   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - instruction fetch unit: PC, imem issue, squash, decode FIFO
// Optional feature macro: IFETCH_PERF_CNT_EN (adds perf_fetched / perf_bubbles)
// Parameters: XLEN, ADDR_W (imem word-address width), RESET_PC, DEPTH (FIFO entries)
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   imem_en, imem_addr           read strobe and word address to instruction memory
//   imem_rdata                   read data, valid the cycle after imem_en
//   redirect_valid, redirect_pc  load a new fetch PC, squashing in-flight work
//   inst_valid, inst_ready       decode handshake on the FIFO head
//   inst, inst_pc                instruction at the FIFO head and its PC
//   perf_fetched, perf_bubbles   accepted-instruction and starved-cycle counters
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter int               XLEN     = XLEN_DEF,
  parameter int               ADDR_W   = 14,
  parameter logic [XLEN-1:0]  RESET_PC = XLEN'(RESET_PC_DEF),
  parameter int               DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [XLEN-1:0]   imem_rdata,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [XLEN-1:0]   inst,
`ifdef IFETCH_PERF_CNT_EN
  output logic [XLEN-1:0]   inst_pc,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_bubbles
`else
  output logic [XLEN-1:0]   inst_pc
`endif
);

  localparam int            CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0]   DEPTH_V = (CW+1)'(DEPTH);

  logic [XLEN-1:0]   fetch_pc;
  logic [XLEN-1:0]   inflight_pc;
  logic              inflight;
  logic [CW-1:0]     count;
  logic [CW:0]       occupancy;
  logic              pop;
  logic              push;
  logic              issue;
  logic [2*XLEN-1:0] fifo_din;
  logic [2*XLEN-1:0] fifo_dout;

  assign pop = inst_valid && inst_ready;

  // Slots already committed (stored + in flight) after this cycle's pop; an
  // issue is only allowed when its response is guaranteed a free slot.
  assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};
  assign issue     = !rst && !redirect_valid && (occupancy < DEPTH_V);

  assign imem_en   = issue;
  assign imem_addr = fetch_pc[ADDR_W+1:2];

  // A response landing in a redirect cycle belongs to the old path: squash it.
  assign push     = inflight && !redirect_valid;
  assign fifo_din = {imem_rdata, inflight_pc};

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= fetch_pc;
      end
      if (redirect_valid) begin
        fetch_pc <= redirect_pc & ~XLEN'(3);
      end else if (issue) begin
        fetch_pc <= fetch_pc + XLEN'(4);
      end
    end
  end

  ifetch_fifo #(
    .WIDTH (2*XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .count (count)
  );

  assign inst_valid = (count != '0);
  assign inst       = fifo_dout[2*XLEN-1:XLEN];
  assign inst_pc    = fifo_dout[XLEN-1:0];

`ifdef IFETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_bubbles <= '0;
    end else begin
      if (pop) begin
        perf_fetched <= perf_fetched + 32'd1;
      end
      if (inst_ready && !inst_valid) begin
        perf_bubbles <= perf_bubbles + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// tb/tb_ifetch_unit.sv - self-checking bench for ifetch_unit
module tb_ifetch_unit;

  localparam int          XLEN     = 32;
  localparam int          ADDR_W   = 14;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              imem_en;
  logic [ADDR_W-1:0] imem_addr;
  logic [XLEN-1:0]   imem_rdata = '0;
  logic              redirect_valid = 1'b0;
  logic [XLEN-1:0]   redirect_pc = '0;
  logic              inst_valid;
  logic              inst_ready = 1'b0;
  logic [XLEN-1:0]   inst;
  logic [XLEN-1:0]   inst_pc;
`ifdef IFETCH_PERF_CNT_EN
  logic [31:0]       perf_fetched;
  logic [31:0]       perf_bubbles;
`endif

  int checks = 0;
  int errors = 0;
  int n_pops = 0;
  logic [63:0] sb[$];

  always #5 clk = ~clk;

  ifetch_unit #(
    .XLEN     (XLEN),
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_en        (imem_en),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
`ifdef IFETCH_PERF_CNT_EN
    .inst_pc        (inst_pc),
    .perf_fetched   (perf_fetched),
    .perf_bubbles   (perf_bubbles)
`else
    .inst_pc        (inst_pc)
`endif
  );

  function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
    return 32'h1000 + 32'(a);
  endfunction

  function automatic logic [31:0] word_of_pc(input logic [31:0] pc);
    logic [ADDR_W-1:0] a;
    a = pc[ADDR_W+1:2];
    return mem_word(a);
  endfunction

  // One-cycle-latency synchronous instruction memory
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= mem_word(imem_addr);
  end

  // Scoreboard: every accepted instruction must match the next expected entry
  always @(negedge clk) begin
    logic [63:0] exp_e;
    if (!rst && inst_valid && inst_ready) begin
      n_pops++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_underrun got inst=%h pc=%h with no expected entry", inst, inst_pc);
      end else begin
        exp_e = sb.pop_front();
        if ({inst, inst_pc} !== exp_e) begin
          errors++;
          $display("FAIL sb_pop got inst=%h pc=%h expected inst=%h pc=%h",
                   inst, inst_pc, exp_e[63:32], exp_e[31:0]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_fill(input logic [31:0] start_pc, input int n);
    logic [31:0] pc;
    sb.delete();
    for (int i = 0; i < n; i++) begin
      pc = start_pc + 32'(4 * i);
      sb.push_back({word_of_pc(pc), pc});
    end
  endtask

  // Leaves the bench at posedge+1 of cycle 0 (first cycle with rst low)
  task automatic do_reset(input logic rdy);
    rst = 1'b1;
    redirect_valid = 1'b0;
    inst_ready = rdy;
    sb.delete();
    repeat (3) step();
    sb_fill(RESET_PC, 40);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    inst_ready = 1'b0;
    redirect_valid = 1'b0;
    step();
    step();
    @(negedge clk);
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b expected 0", inst_valid); end
    checks++; if (imem_en !== 1'b0) begin errors++; $display("FAIL rst_imem_en got %b expected 0", imem_en); end
    checks++; if (inst !== 32'h0) begin errors++; $display("FAIL rst_inst got %h expected 0", inst); end
    checks++; if (inst_pc !== 32'h0) begin errors++; $display("FAIL rst_inst_pc got %h expected 0", inst_pc); end
    step();
    sb_fill(RESET_PC, 40);
    rst = 1'b0;
    inst_ready = 1'b1;
    @(negedge clk);
    checks++; if (imem_en !== 1'b1 || imem_addr !== 14'h0) begin errors++; $display("FAIL c0_issue got en=%b addr=%h expected en=1 addr=0", imem_en, imem_addr); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL c0_valid got %b expected 0", inst_valid); end
    step();
    @(negedge clk);
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL c1_valid got %b expected 0", inst_valid); end
    checks++; if (imem_addr !== 14'h1) begin errors++; $display("FAIL c1_addr got %h expected 1", imem_addr); end
    step();
    @(negedge clk);
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst !== 32'h1000) begin
      errors++; $display("FAIL c2_first got valid=%b inst=%h pc=%h expected 1 00001000 00000000", inst_valid, inst, inst_pc);
    end
  endtask

  task automatic test_stream();
    int p0;
    step();
    p0 = n_pops;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL stream_valid cycle %0d got %b expected 1", c + 3, inst_valid); end
      step();
    end
    checks++; if (n_pops - p0 !== 9) begin errors++; $display("FAIL stream_count got %0d expected 9", n_pops - p0); end
  endtask

  task automatic test_stall();
    int p0;
    do_reset(1'b0);
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      checks++; if (imem_en !== (c < 2)) begin errors++; $display("FAIL stall_imem_en cycle %0d got %b expected %b", c, imem_en, (c < 2)); end
      if (c >= 2) begin
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst !== 32'h1000) begin
          errors++; $display("FAIL stall_head cycle %0d got valid=%b inst=%h pc=%h expected 1 00001000 00000000", c, inst_valid, inst, inst_pc);
        end
      end
      step();
    end
    inst_ready = 1'b1;
    p0 = n_pops;
    repeat (8) step();
    checks++; if (n_pops - p0 !== 8) begin errors++; $display("FAIL stall_resume_count got %0d expected 8", n_pops - p0); end
  endtask

  task automatic test_redirect_full();
    int p0;
    do_reset(1'b0);
    repeat (4) step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h43;
    @(negedge clk);
    checks++; if (imem_en !== 1'b0) begin errors++; $display("FAIL redir_no_issue got %b expected 0", imem_en); end
    step();
    redirect_valid = 1'b0;
    inst_ready = 1'b1;
    sb_fill(32'h40, 40);
    p0 = n_pops;
    @(negedge clk);
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL redir_n1_valid got %b expected 0", inst_valid); end
    checks++; if (imem_en !== 1'b1 || imem_addr !== 14'h10) begin errors++; $display("FAIL redir_n1_issue got en=%b addr=%h expected en=1 addr=0010", imem_en, imem_addr); end
    step();
    @(negedge clk);
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL redir_n2_valid got %b expected 0", inst_valid); end
    step();
    @(negedge clk);
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h40) begin errors++; $display("FAIL redir_n3 got valid=%b pc=%h expected 1 00000040", inst_valid, inst_pc); end
    repeat (5) step();
    checks++; if (n_pops - p0 !== 5) begin errors++; $display("FAIL redir_count got %0d expected 5", n_pops - p0); end
  endtask

  task automatic test_redirect_pop();
    int p0;
    do_reset(1'b1);
    repeat (4) step();
    p0 = n_pops;
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    step();
    checks++; if (n_pops - p0 !== 1) begin errors++; $display("FAIL redir_pop_count got %0d expected 1", n_pops - p0); end
    redirect_valid = 1'b0;
    sb_fill(32'h200, 40);
    p0 = n_pops;
    repeat (4) step();
    checks++; if (n_pops - p0 !== 2) begin errors++; $display("FAIL redir_pop_after got %0d expected 2", n_pops - p0); end
  endtask

  task automatic test_wrap();
    do_reset(1'b1);
    step();
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFF8;
    step();
    redirect_valid = 1'b0;
    sb_fill(32'hFFF8, 40);
    @(negedge clk);
    checks++; if (imem_addr !== 14'h3FFE) begin errors++; $display("FAIL wrap_addr0 got %h expected 3ffe", imem_addr); end
    step();
    @(negedge clk);
    checks++; if (imem_addr !== 14'h3FFF) begin errors++; $display("FAIL wrap_addr1 got %h expected 3fff", imem_addr); end
    step();
    @(negedge clk);
    checks++; if (imem_addr !== 14'h0000) begin errors++; $display("FAIL wrap_addr2 got %h expected 0000", imem_addr); end
    checks++; if (inst_pc !== 32'hFFF8) begin errors++; $display("FAIL wrap_pc0 got %h expected 0000fff8", inst_pc); end
    step();
    @(negedge clk);
    checks++; if (inst_pc !== 32'hFFFC || inst !== 32'h4FFF) begin errors++; $display("FAIL wrap_pc1 got inst=%h pc=%h expected 00004fff 0000fffc", inst, inst_pc); end
    step();
    @(negedge clk);
    checks++; if (inst_pc !== 32'h10000 || inst !== 32'h1000) begin errors++; $display("FAIL wrap_pc2 got inst=%h pc=%h expected 00001000 00010000", inst, inst_pc); end
    step();
  endtask

`ifdef IFETCH_PERF_CNT_EN
  task automatic test_perf();
    do_reset(1'b1);
    repeat (9) step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h80;
    step();
    redirect_valid = 1'b0;
    sb_fill(32'h80, 40);
    repeat (4) step();
    inst_ready = 1'b0;
    checks++; if (perf_fetched !== 32'd10) begin errors++; $display("FAIL perf_fetched got %0d expected 10", perf_fetched); end
    checks++; if (perf_bubbles !== 32'd4) begin errors++; $display("FAIL perf_bubbles got %0d expected 4", perf_bubbles); end
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_full();
    test_redirect_pop();
    test_wrap();
`ifdef IFETCH_PERF_CNT_EN
    test_perf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
